// File: rtl/hsid_x_obi_arb.sv
// OBI bus types shared by the HSID memory readers, and the round-robin arbiter
// that multiplexes several readers onto one OBI manager port with in-order response routing.
package hsid_x_obi_inf_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

// state     | meaning
// ST_OPEN   | free to pick the next round-robin candidate
// ST_LOCKED | an ungranted address phase is pending; selection pinned to lock_id
module hsid_x_obi_arb #(
   parameter int NUM_MGR         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_WIDTH        = $clog2(NUM_MGR),
   localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  hsid_x_obi_inf_pkg::obi_req_t  mgr_req_i [NUM_MGR],
   output hsid_x_obi_inf_pkg::obi_resp_t mgr_rsp_o [NUM_MGR],
   output hsid_x_obi_inf_pkg::obi_req_t  sub_req_o,
   input  hsid_x_obi_inf_pkg::obi_resp_t sub_rsp_i,
   output logic [CNT_W-1:0]             outstanding_o,
   output logic                         err_o,
   input  logic                         clear
);

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

   lock_state_t         lock_state;
   logic [ID_WIDTH-1:0] lock_id;
   logic [ID_WIDTH-1:0] rr_ptr;

   logic [ID_WIDTH-1:0] id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ID_WIDTH-1:0] head;

   logic [ID_WIDTH-1:0] cand;
   logic                cand_vld;
   logic [ID_WIDTH-1:0] sel;
   logic                sel_vld;
   logic                push;
   logic                pop;
   logic                spurious;
   int                  idx;

   assign fifo_full     = (count == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty    = (count == '0);
   assign head          = id_fifo[rd_ptr];
   assign outstanding_o = count;

   always_comb begin
      cand     = '0;
      cand_vld = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_MGR; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_MGR) idx = idx - NUM_MGR;
         if (!cand_vld && mgr_req_i[ID_WIDTH'(idx)].req) begin
            cand_vld = 1'b1;
            cand     = ID_WIDTH'(idx);
         end
      end
      if (lock_state == ST_LOCKED) begin
         sel     = lock_id;
         sel_vld = mgr_req_i[lock_id].req;
      end else begin
         sel     = cand;
         sel_vld = cand_vld;
      end
   end

   // Outputs are forced to their idle values while reset is held.
   always_comb begin
      sub_req_o = '0;
      if (rst_n && sel_vld && !fifo_full)
         sub_req_o = mgr_req_i[sel];
      push     = sub_req_o.req && sub_rsp_i.gnt;
      pop      = rst_n && sub_rsp_i.rvalid && !fifo_empty;
      spurious = sub_rsp_i.rvalid && fifo_empty;
      for (int i = 0; i < NUM_MGR; i++) begin
         mgr_rsp_o[i]        = '0;
         mgr_rsp_o[i].gnt    = push && (sel == ID_WIDTH'(i));
         mgr_rsp_o[i].rvalid = pop && (head == ID_WIDTH'(i));
         mgr_rsp_o[i].rdata  = rst_n ? sub_rsp_i.rdata : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= ST_OPEN;
         lock_id    <= '0;
         rr_ptr     <= '0;
      end else begin
         if (push) begin
            lock_state <= ST_OPEN;
            rr_ptr     <= (sel == ID_WIDTH'(NUM_MGR - 1)) ? '0 : sel + ID_WIDTH'(1);
         end else if (sub_req_o.req) begin
            lock_state <= ST_LOCKED;
            lock_id    <= sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) id_fifo[i] <= '0;
      end else begin
         if (push) begin
            id_fifo[wr_ptr] <= sel;
            wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   // A spurious rvalid outranks clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_o <= 1'b0;
      else if (spurious)
         err_o <= 1'b1;
      else if (clear)
         err_o <= 1'b0;
   end

endmodule
